// File: rtl/riscv_pkg.sv
// Shared core types: load/store size encodings and the store-buffer entry layout.
// Pure declarations, no logic, no timing.
// Imported by the store buffer and its matcher.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] AC_B  = 3'b000;
  localparam logic [2:0] AC_H  = 3'b001;
  localparam logic [2:0] AC_W  = 3'b010;
  localparam logic [2:0] AC_BU = 3'b100;
  localparam logic [2:0] AC_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      ac;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Word-address match of a load against buffered stores; picks the youngest match.
// Latency: purely combinational.
// Backpressure: none; the caller turns a non-forwardable match into a stall.
module sb_match
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                  load,
  input  logic [XLEN-1:0]       addr,
  input  logic [2:0]            ac,
  input  logic [DEPTH-1:0]      valid,
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         tail,
  output logic                  any_match,
  output logic [PW-1:0]         youngest,
  output logic                  hit
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk from the newest entry (tail-1) back towards the oldest; first match wins.
  always_comb begin
    found    = 1'b0;
    youngest = '0;
    idx      = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - PW'(k);
      if (!found && valid[idx] && (entries[idx].addr[XLEN-1:2] == addr[XLEN-1:2])) begin
        found    = 1'b1;
        youngest = idx;
      end
    end
  end

  assign any_match = load & found;
  assign hit       = any_match
                   & (entries[youngest].ac == AC_W)
                   & (addr[1:0] == 2'b00)
                   & (ac == AC_W);

endmodule

// File: rtl/store_buffer.sv
// Queues committed stores and drains them to the single data-memory port; forwards to LW.
// Latency: a store accepted at edge N reaches data_mem at edge N+1 at the earliest; forwarding is same-cycle.
// Backpressure: StallM on full-without-drain, on non-forwardable load overlap, and during fence until empty.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StoreM,
  input  logic                  LoadM,
  input  logic                  FenceM,
  input  logic [DATA_WIDTH-1:0] AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            AddressingControlM,
  output logic                  StallM,
  output logic                  FwdHitM,
  output logic [DATA_WIDTH-1:0] FwdDataM,
  output logic                  MemWriteD,
  output logic [DATA_WIDTH-1:0] AddrD,
  output logic [DATA_WIDTH-1:0] WriteDataD,
  output logic [2:0]            AddressingControlD,
  output logic                  EmptyM
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] mem;
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         youngest;
  logic [PW:0]           count;
  logic                  any_match;
  logic                  hit;
  logic                  conflict;
  logic                  full;
  logic                  pop;
  logic                  push;

  sb_match #(.DEPTH(DEPTH), .PW(PW)) u_match (
    .load      (LoadM),
    .addr      (AddrM),
    .ac        (AddressingControlM),
    .valid     (valid),
    .entries   (mem),
    .tail      (tail),
    .any_match (any_match),
    .youngest  (youngest),
    .hit       (hit)
  );

  assign EmptyM   = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign conflict = LoadM & any_match & ~hit;
  // The port is free whenever no load needs it, or a conflict/fence forces draining.
  assign pop      = ~EmptyM & (~LoadM | conflict | FenceM);
  assign StallM   = (StoreM & full & ~pop) | conflict | (FenceM & ~EmptyM);
  assign push     = StoreM & ~StallM;

  assign MemWriteD          = pop;
  assign AddrD              = mem[head].addr;
  assign WriteDataD         = mem[head].data;
  assign AddressingControlD = mem[head].ac;

  assign FwdHitM  = hit;
  assign FwdDataM = hit ? mem[youngest].data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // Pop before push: when full, head==tail and the new entry's valid must win.
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        mem[tail]   <= '{addr: AddrM, data: WriteDataM, ac: AddressingControlM};
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
